// File: rtl/tdes_pkg.sv
// rtl/tdes_pkg.sv - shared constants and state encoding for the TDES CBC sequencer
package tdes_pkg;

    localparam int BLK_W  = 64;
    localparam int WDOG_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        KLOAD,
        KWAIT,
        DLOAD,
        DWAIT,
        DONE
    } tdes_state_t;

endpackage

// File: rtl/tdes_cbc_ctrl.sv
// rtl/tdes_cbc_ctrl.sv - CBC sequencer around the TDES core with core-response watchdog
// Optional ECB pass-through per block: define TDES_ECB_BYPASS_EN.
module tdes_cbc_ctrl
    import tdes_pkg::*;
#(
    parameter int WDOG_CYCLES = 255
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [1:BLK_W]   Key1,
    input  logic [1:BLK_W]   Key2,
    input  logic [1:BLK_W]   Key3,
    input  logic [1:BLK_W]   IV,
    input  logic             Krdy,
    input  logic [1:BLK_W]   Din,
    input  logic             Drdy,
    input  logic             ENC,
`ifdef TDES_ECB_BYPASS_EN
    input  logic             ECB,
`endif
    output logic [1:BLK_W]   Dout,
    output logic             Dvld,
    output logic             BSY,
    output logic             ERR,
    output logic [1:BLK_W]   core_Din,
    output logic [1:BLK_W]   core_Key1,
    output logic [1:BLK_W]   core_Key2,
    output logic [1:BLK_W]   core_Key3,
    output logic             core_Krdy,
    output logic             core_Drdy,
    output logic             core_ENC,
    output logic             core_EN,
    input  logic [1:BLK_W]   core_Dout,
    input  logic             core_BSY,
    input  logic             core_Dvld
);

    localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(WDOG_CYCLES - 1);

    tdes_state_t       state;
    logic [1:BLK_W]    key1_reg, key2_reg, key3_reg;
    logic [1:BLK_W]    chain;
    logic [1:BLK_W]    din_reg;
    logic              enc_reg;
    logic [WDOG_W-1:0] wdog;
    logic              bypass;

`ifdef TDES_ECB_BYPASS_EN
    logic ecb_reg;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            ecb_reg <= 1'b0;
        else if (state == IDLE && !Krdy && Drdy)
            ecb_reg <= ECB;
    end

    assign bypass = ecb_reg;
`else
    assign bypass = 1'b0;
`endif

    assign BSY       = (state != IDLE);
    assign core_EN   = 1'b1;
    assign core_ENC  = enc_reg;
    assign core_Key1 = key1_reg;
    assign core_Key2 = key2_reg;
    assign core_Key3 = key3_reg;
    assign core_Din  = (enc_reg && !bypass) ? (din_reg ^ chain) : din_reg;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            key1_reg  <= '0;
            key2_reg  <= '0;
            key3_reg  <= '0;
            chain     <= '0;
            din_reg   <= '0;
            enc_reg   <= 1'b0;
            wdog      <= '0;
            Dout      <= '0;
            Dvld      <= 1'b0;
            ERR       <= 1'b0;
            core_Krdy <= 1'b0;
            core_Drdy <= 1'b0;
        end else begin
            core_Krdy <= 1'b0;
            core_Drdy <= 1'b0;
            Dvld      <= 1'b0;
            case (state)
                IDLE: begin
                    // Key load has priority; a simultaneous Drdy is dropped
                    if (Krdy) begin
                        key1_reg  <= Key1;
                        key2_reg  <= Key2;
                        key3_reg  <= Key3;
                        chain     <= IV;
                        ERR       <= 1'b0;
                        core_Krdy <= 1'b1;
                        state     <= KLOAD;
                    end else if (Drdy) begin
                        din_reg   <= Din;
                        enc_reg   <= ENC;
                        core_Drdy <= 1'b1;
                        state     <= DLOAD;
                    end
                end
                KLOAD: begin
                    wdog  <= '0;
                    state <= KWAIT;
                end
                KWAIT: begin
                    if (!core_BSY) begin
                        state <= IDLE;
                    end else if (wdog == WDOG_LIM) begin
                        ERR   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                DLOAD: begin
                    wdog  <= '0;
                    state <= DWAIT;
                end
                DWAIT: begin
                    if (core_Dvld) begin
                        if (bypass) begin
                            Dout <= core_Dout;
                        end else if (enc_reg) begin
                            Dout  <= core_Dout;
                            chain <= core_Dout;
                        end else begin
                            Dout  <= core_Dout ^ chain;
                            chain <= din_reg;
                        end
                        state <= DONE;
                    end else if (wdog == WDOG_LIM) begin
                        // Abandon the block; chain keeps its previous value
                        ERR   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                DONE: begin
                    Dvld  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdes_cbc_ctrl.sv
// tb/tb_tdes_cbc_ctrl.sv - randomized self-checking bench for tdes_cbc_ctrl with a toy core model
module tb_tdes_cbc_ctrl;

    localparam int WDOG = 16;
    localparam logic [63:0] KT  = 64'h10316E028C8F3B4A;
    localparam logic [63:0] CT0 = 64'h82DCBAFBDEAB6602;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic [63:0] Key1, Key2, Key3, IV, Din;
    logic        Krdy, Drdy, ENC;
`ifdef TDES_ECB_BYPASS_EN
    logic        ECB;
`endif
    logic [63:0] Dout;
    logic        Dvld, BSY, ERR;
    logic [63:0] core_Din, core_Key1, core_Key2, core_Key3, core_Dout;
    logic        core_Krdy, core_Drdy, core_ENC, core_EN, core_BSY, core_Dvld;

    always #5 CLK = ~CLK;

    tdes_cbc_ctrl #(.WDOG_CYCLES(WDOG)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .Key1(Key1), .Key2(Key2), .Key3(Key3), .IV(IV),
        .Krdy(Krdy), .Din(Din), .Drdy(Drdy), .ENC(ENC),
`ifdef TDES_ECB_BYPASS_EN
        .ECB(ECB),
`endif
        .Dout(Dout), .Dvld(Dvld), .BSY(BSY), .ERR(ERR),
        .core_Din(core_Din), .core_Key1(core_Key1), .core_Key2(core_Key2), .core_Key3(core_Key3),
        .core_Krdy(core_Krdy), .core_Drdy(core_Drdy), .core_ENC(core_ENC), .core_EN(core_EN),
        .core_Dout(core_Dout), .core_BSY(core_BSY), .core_Dvld(core_Dvld)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Toy invertible block cipher, calibrated so E(KT,0) equals the reference ciphertext
    logic [63:0] tw;

    function automatic logic [63:0] rotl5(input logic [63:0] x);
        return {x[58:0], x[63:59]};
    endfunction

    function automatic logic [63:0] rotr5(input logic [63:0] x);
        return {x[4:0], x[63:5]};
    endfunction

    function automatic logic [63:0] cip_e(input logic [63:0] k, input logic [63:0] x);
        return rotl5(x ^ k) ^ k ^ tw;
    endfunction

    function automatic logic [63:0] cip_d(input logic [63:0] k, input logic [63:0] y);
        return rotr5(y ^ k ^ tw) ^ k;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Behavioural TDES core
    int          cyc = 0;
    int          cdv_cyc = 0;
    int          cdrdy_cnt = 0;
    int          dvld_cnt = 0;
    bit          mute = 1'b0;
    bit          spur = 1'b0;
    logic [63:0] ck = '0;
    logic [63:0] cin;
    logic        cenc;

    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) if (Dvld === 1'b1) dvld_cnt <= dvld_cnt + 1;

    initial begin
        int dcnt, kcnt;
        dcnt = 0;
        kcnt = 0;
        core_Dvld = 1'b0;
        core_BSY = 1'b0;
        core_Dout = '0;
        forever begin
            @(posedge CLK);
            #1;
            core_Dvld = 1'b0;
            if (!RSTn) begin
                dcnt = 0;
                kcnt = 0;
                core_BSY = 1'b0;
                continue;
            end
            if (core_Krdy) begin
                ck = core_Key1 ^ core_Key2 ^ core_Key3;
                kcnt = $urandom_range(1, 4);
                core_BSY = 1'b1;
            end else if (kcnt > 0) begin
                kcnt--;
                if (kcnt == 0) core_BSY = 1'b0;
            end
            if (spur) begin
                spur = 1'b0;
                core_Dout = rnd64();
                core_Dvld = 1'b1;
            end
            if (core_Drdy) begin
                cdrdy_cnt++;
                cin = core_Din;
                cenc = core_ENC;
                if (!mute) dcnt = $urandom_range(1, 6);
            end else if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) begin
                    core_Dout = cenc ? cip_e(ck, cin) : cip_d(ck, cin);
                    core_Dvld = 1'b1;
                    cdv_cyc = cyc;
                end
            end
        end
    end

    // Reference CBC model: key fold and chain value as the host sees them
    logic [63:0] rk = '0;
    logic [63:0] rchain = '0;
    int          exp_dvld = 0;

    task automatic load_keys(input logic [63:0] k1, input logic [63:0] k2, input logic [63:0] k3,
                             input logic [63:0] iv, input bit with_drdy);
        int n;
        @(negedge CLK);
        Key1 = k1; Key2 = k2; Key3 = k3; IV = iv;
        Krdy = 1'b1; Drdy = with_drdy; Din = rnd64(); ENC = 1'($urandom_range(0, 1));
        @(posedge CLK);
        #1;
        Krdy = 1'b0; Drdy = 1'b0;
        Key1 = rnd64(); Key2 = rnd64(); Key3 = rnd64(); IV = rnd64();
        rk = k1 ^ k2 ^ k3;
        rchain = iv;
        @(negedge CLK);
        check("krdy_pulse", 64'(core_Krdy), 64'd1);
        check("krdy_no_drdy", 64'(core_Drdy), 64'd0);
        check("krdy_bsy", 64'(BSY), 64'd1);
        check("err_cleared", 64'(ERR), 64'd0);
        check("core_key1", core_Key1, k1);
        check("core_key3", core_Key3, k3);
        @(negedge CLK);
        check("krdy_1cyc", 64'(core_Krdy), 64'd0);
        n = 0;
        while (BSY === 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("kload_done", 64'(BSY), 64'd0);
    endtask

    task automatic run_block(input logic [63:0] din, input bit enc, input bit ecb, input bit poke,
                             output logic [63:0] got);
        logic [63:0] pre, out, c;
        int n;
        bit seen;
        @(negedge CLK);
        Din = din; ENC = enc; Drdy = 1'b1;
`ifdef TDES_ECB_BYPASS_EN
        ECB = ecb;
`endif
        @(posedge CLK);
        #1;
        Drdy = 1'b0; Din = rnd64(); ENC = 1'($urandom_range(0, 1));
        pre = (enc && !ecb) ? (din ^ rchain) : din;
        if (enc) begin
            out = cip_e(rk, pre);
            if (!ecb) rchain = out;
        end else begin
            c = cip_d(rk, din);
            out = ecb ? c : (c ^ rchain);
            if (!ecb) rchain = din;
        end
        exp_dvld++;
        @(negedge CLK);
        check("core_drdy", 64'(core_Drdy), 64'd1);
        check("core_din", core_Din, pre);
        check("core_enc", 64'(core_ENC), 64'(enc));
        if (poke) begin
            @(negedge CLK);
            Drdy = 1'b1; Din = rnd64();
            @(posedge CLK);
            #1;
            Drdy = 1'b0;
        end
        seen = 1'b0;
        n = 0;
        while (!seen && n < 40) begin
            @(negedge CLK);
            seen = (Dvld === 1'b1);
            n++;
        end
        check("dvld_seen", 64'(seen), 64'd1);
        got = Dout;
        check("dout", Dout, out);
        check("latency", 64'(cyc - cdv_cyc), 64'd2);
        @(negedge CLK);
        check("dvld_1cyc", 64'(Dvld), 64'd0);
    endtask

    task automatic watchdog_block();
        int n, d0;
        d0 = dvld_cnt;
        mute = 1'b1;
        @(negedge CLK);
        Din = rnd64(); ENC = 1'($urandom_range(0, 1)); Drdy = 1'b1;
`ifdef TDES_ECB_BYPASS_EN
        ECB = 1'b0;
`endif
        @(posedge CLK);
        #1;
        Drdy = 1'b0;
        @(negedge CLK);
        check("wd_core_drdy", 64'(core_Drdy), 64'd1);
        n = 0;
        while (n < 100) begin
            @(negedge CLK);
            if (BSY !== 1'b1) break;
            n++;
        end
        check("wd_cycles", 64'(n), 64'(WDOG));
        check("wd_err", 64'(ERR), 64'd1);
        check("wd_no_dvld", 64'(dvld_cnt), 64'(d0));
        mute = 1'b0;
    endtask

    initial begin
        logic [63:0] got;
        int n0, d0;
        bit ecb;
        tw = rotl5(KT) ^ KT ^ CT0;
        RSTn = 1'b0;
        Key1 = '0; Key2 = '0; Key3 = '0; IV = '0; Din = '0;
        Krdy = 1'b0; Drdy = 1'b0; ENC = 1'b0;
`ifdef TDES_ECB_BYPASS_EN
        ECB = 1'b0;
`endif
        repeat (2) @(negedge CLK);
        check("rst_dout", Dout, 64'd0);
        check("rst_bsy", 64'(BSY), 64'd0);
        check("rst_core_en", 64'(core_EN), 64'd1);
        check("rst_core_krdy", 64'(core_Krdy), 64'd0);
        RSTn = 1'b1;

        load_keys(KT, KT, KT, 64'd0, 1'b0);
        run_block(64'd0, 1'b1, 1'b0, 1'b0, got);
        check("plan_enc1", got, CT0);
        run_block(CT0, 1'b1, 1'b0, 1'b0, got);
        check("plan_enc2", got, CT0);
        load_keys(KT, KT, KT, 64'd0, 1'b0);
        run_block(CT0, 1'b0, 1'b0, 1'b0, got);
        check("plan_dec1", got, 64'd0);
        run_block(CT0, 1'b0, 1'b0, 1'b0, got);
        check("plan_dec2", got, CT0);

        n0 = cdrdy_cnt;
        run_block(rnd64(), 1'($urandom_range(0, 1)), 1'b0, 1'b1, got);
        repeat (4) @(negedge CLK);
        check("poke_ignored_bsy", 64'(BSY), 64'd0);
        check("poke_one_core_drdy", 64'(cdrdy_cnt - n0), 64'd1);

        n0 = cdrdy_cnt;
        d0 = dvld_cnt;
        load_keys(rnd64(), rnd64(), rnd64(), rnd64(), 1'b1);
        repeat (5) @(negedge CLK);
        check("krdy_drdy_no_core_drdy", 64'(cdrdy_cnt), 64'(n0));
        check("krdy_drdy_no_dvld", 64'(dvld_cnt), 64'(d0));

        d0 = dvld_cnt;
        spur = 1'b1;
        repeat (5) @(negedge CLK);
        check("spur_no_dvld", 64'(dvld_cnt), 64'(d0));
        check("spur_idle", 64'(BSY), 64'd0);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 5) == 0)
                load_keys(rnd64(), rnd64(), rnd64(), rnd64(), 1'b0);
`ifdef TDES_ECB_BYPASS_EN
            ecb = ($urandom_range(0, 3) == 0);
`else
            ecb = 1'b0;
`endif
            run_block(rnd64(), 1'($urandom_range(0, 1)), ecb, 1'b0, got);
        end

        watchdog_block();
        run_block(rnd64(), 1'b1, 1'b0, 1'b0, got);
        run_block(rnd64(), 1'b0, 1'b0, 1'b0, got);
        check("err_sticky", 64'(ERR), 64'd1);
        load_keys(rnd64(), rnd64(), rnd64(), rnd64(), 1'b0);
        run_block(rnd64(), 1'b1, 1'b0, 1'b0, got);

        watchdog_block();
        mute = 1'b1;
        d0 = dvld_cnt;
        @(negedge CLK);
        Din = rnd64(); ENC = 1'b1; Drdy = 1'b1;
        @(posedge CLK);
        #1;
        Drdy = 1'b0;
        repeat (3) @(negedge CLK);
        check("err_drdy_accepted", 64'(BSY), 64'd1);
        @(posedge CLK);
        #2;
        RSTn = 1'b0;
        #1;
        check("arst_dout", Dout, 64'd0);
        check("arst_bsy", 64'(BSY), 64'd0);
        check("arst_err", 64'(ERR), 64'd0);
        check("arst_core_drdy", 64'(core_Drdy), 64'd0);
        check("arst_core_enc", 64'(core_ENC), 64'd0);
        check("arst_core_en", 64'(core_EN), 64'd1);
        check("arst_key", core_Key1, 64'd0);
        mute = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        rchain = '0;
        repeat (6) @(negedge CLK);
        check("arst_no_dvld", 64'(dvld_cnt), 64'(d0));
        run_block(rnd64(), 1'b1, 1'b0, 1'b0, got);
        run_block(rnd64(), 1'b0, 1'b0, 1'b0, got);

        repeat (3) @(negedge CLK);
        check("dvld_total", 64'(dvld_cnt), 64'(exp_dvld));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tdes_cbc_ctrl.md
Name: tdes_cbc_ctrl

Overview:
CBC mode-of-operation sequencer wrapped around the existing TDES core. It latches keys and IV from the host and handles CBC chaining (XOR pre/post-processing, chain register update). It drives the core's Krdy/Drdy handshakes, waits for Dvld, and returns one 64-bit block per request. A watchdog flags a core that never answers.

Parameters:
WDOG_CYCLES, 255, cycles allowed from core_Drdy/core_Krdy pulse to core completion before ERR is raised (8-bit counter, legal range 1..255).

Ports:
CLK  in  1  system clock, all logic on rising edge
RSTn  in  1  asynchronous active-low reset
Key1, Key2, Key3  in  64 each  host keys, bit order [1:64]
IV  in  64  host initial vector [1:64]
Krdy  in  1  host pulse: latch keys+IV, program core
Din  in  64  host data block [1:64]
Drdy  in  1  host pulse: process Din
ENC  in  1  1 encrypt, 0 decrypt; sampled with Drdy
Dout  out  64  result block [1:64]
Dvld  out  1  one-cycle pulse, Dout valid
BSY  out  1  controller busy; Krdy/Drdy ignored while high
ERR  out  1  sticky watchdog error, cleared by next accepted Krdy
core_Din, core_Key1, core_Key2, core_Key3  out  64 each  to TDES core
core_Krdy, core_Drdy, core_ENC, core_EN  out  1 each  to TDES core
core_Dout  in  64  from TDES core
core_BSY, core_Dvld  in  1 each  from TDES core

Behaviour:
- Reset: Dout=0, Dvld=0, BSY=0, ERR=0, core_Krdy=0, core_Drdy=0, core_ENC=0, core_EN=1. Key, IV and chain registers go to 0. State goes to IDLE. A reset mid-operation aborts the block and produces no Dvld.
- core_Key1..3 are driven from the latched key registers, never directly from the host inputs.
- States:
  - IDLE: BSY=0. Krdy: latch Key1..3, IV into chain reg, clear ERR, go to KLOAD. Drdy (no Krdy): latch Din into din_reg, ENC into enc_reg, go to DLOAD. Krdy and Drdy in the same cycle: Krdy wins and Drdy is dropped.
  - KLOAD: pulse core_Krdy for exactly 1 cycle, then go to KWAIT.
  - KWAIT: wait for core_BSY=0 (earliest check is the cycle after the pulse), then go to IDLE.
  - DLOAD: core_Din = enc_reg ? din_reg^chain : din_reg. core_ENC=enc_reg. Pulse core_Drdy for 1 cycle, then go to DWAIT.
  - DWAIT: wait for core_Dvld. On core_Dvld:
    - Encrypt: Dout <= core_Dout and chain <= core_Dout.
    - Decrypt: Dout <= core_Dout^chain and chain <= din_reg.
    - Go to DONE.
  - DONE: Dvld=1 for exactly 1 cycle, then go to IDLE.
- BSY is 1 in every state except IDLE, and rises the cycle after the accepting Krdy/Drdy.
- Latency: Drdy accepted at cycle 0 → core_Drdy at cycle 1 → Dvld 2 cycles after core_Dvld.
- Watchdog:
  - The counter is cleared on entry to KWAIT/DWAIT and increments every cycle in those states.
  - On reaching WDOG_CYCLES: ERR=1, go to IDLE, no Dvld, chain unchanged.
  - ERR clears only on the next accepted Krdy. Drdy is still accepted while ERR=1.
- Core Dvld outside DWAIT is ignored.
- Chain persists across blocks. Only Krdy or reset reloads it.

Optional Feature:
- Macro: TDES_ECB_BYPASS_EN.
- With the macro defined:
  - Extra input port ECB (1 bit) is added and sampled with Drdy.
  - When ECB=1, both the XOR steps and the chain update are skipped: core_Din=din_reg, Dout=core_Dout, chain untouched.
- Without the macro: the port is absent and the block is CBC only.

Decomposition:
- Package tdes_pkg holds:
  - the state encoding (IDLE, KLOAD, KWAIT, DLOAD, DWAIT, DONE);
  - the block-width constant 64;
  - the watchdog counter width 8.
- No sub-module is required. The watchdog counter could optionally be split out as tdes_wdog, but it stays inline.

Test Plan:
- Keys=10316E028C8F3B4A x3, IV=0, Krdy pulse, then encrypt Din=0000000000000000 → core_Krdy one pulse, then Dout=82DCBAFBDEAB6602 with one Dvld pulse.
- Continuing from the previous scenario, encrypt Din=82DCBAFBDEAB6602 → core_Din=0000000000000000, Dout=82DCBAFBDEAB6602.
- Krdy again (IV=0), decrypt 82DCBAFBDEAB6602 then 82DCBAFBDEAB6602 → Dout=0000000000000000 then 82DCBAFBDEAB6602.
- Drdy pulsed while BSY=1, and Krdy+Drdy in the same cycle in IDLE → extra Drdy ignored (exactly one Dvld per accepted block); in the simultaneous case only a key load occurs, with no core_Drdy.
- Core model never asserts core_Dvld, WDOG_CYCLES=16 → ERR=1 after 16 DWAIT cycles, BSY=0, no Dvld; next Krdy clears ERR.
- RSTn low during DWAIT → all outputs at reset values immediately (asynchronous), no Dvld after release, chain=0.
